// File: rtl/audio_mixer_seq.sv
// Sequential audio mixer: snapshots NUM_CH signed channel samples on IN_STB, sums one
// channel per clock into a non-overflowing accumulator, and emits the saturated mix.
module audio_mixer_seq #(
  parameter int NUM_CH    = 4,
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 12
) (
  input  logic                       CLK,
  input  logic                       RESET_n,
  input  logic                       IN_STB,
  input  logic [NUM_CH*IN_WIDTH-1:0] IN,
  input  logic [NUM_CH-1:0]          MUTE,
  input  logic                       OVERRUN_CLR,
  output logic [OUT_WIDTH-1:0]       OUT,
  output logic                       OUT_VALID,
  output logic                       CLIPPED,
  output logic                       BUSY,
  output logic                       OVERRUN
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ACC_W = IN_WIDTH + $clog2(NUM_CH) + 1;
  // Comparison width wide enough for both the accumulator and the output limits
  localparam int SW    = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

  localparam logic signed [SW-1:0] SAT_MAX =
    $signed({{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]                 r_state;
  logic [NUM_CH*IN_WIDTH-1:0] r_in_snap;
  logic [NUM_CH-1:0]          r_mute_snap;
  logic [ACC_W-1:0]           r_acc;
  logic [CH_W-1:0]            r_ch;
  logic                       r_overrun;

  logic [IN_WIDTH-1:0]        w_lane;
  logic [ACC_W-1:0]           w_term;
  logic [ACC_W-1:0]           w_sum;
  logic                       w_last;

  function automatic logic signed [SW-1:0] f_widen(input logic [ACC_W-1:0] a);
    return $signed({{(SW-ACC_W){a[ACC_W-1]}}, a});
  endfunction

  function automatic logic f_clip(input logic [ACC_W-1:0] a);
    logic signed [SW-1:0] v;
    v = f_widen(a);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] f_sat(input logic [ACC_W-1:0] a);
    logic signed [SW-1:0] v;
    v = f_widen(a);
    if (v > SAT_MAX) begin
      return SAT_MAX[OUT_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      return v[OUT_WIDTH-1:0];
    end
  endfunction

  // The snapshot shifts down one lane per ACCUM cycle, so the current channel is always lane 0
  always_comb begin
    w_lane = r_in_snap[IN_WIDTH-1:0];
    if (r_mute_snap[0]) begin
      w_term = {ACC_W{1'b0}};
    end else begin
      w_term = {{(ACC_W-IN_WIDTH){w_lane[IN_WIDTH-1]}}, w_lane};
    end
    w_sum  = r_acc + w_term;
    w_last = (r_ch == CH_W'(NUM_CH-1));
  end

  assign BUSY    = (r_state == ST_ACCUM);
  assign OVERRUN = r_overrun;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= ST_IDLE;
      r_in_snap   <= {(NUM_CH*IN_WIDTH){1'b0}};
      r_mute_snap <= {NUM_CH{1'b0}};
      r_acc       <= {ACC_W{1'b0}};
      r_ch        <= {CH_W{1'b0}};
      OUT         <= {OUT_WIDTH{1'b0}};
      OUT_VALID   <= 1'b0;
      CLIPPED     <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      CLIPPED   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (IN_STB) begin
            r_in_snap   <= IN;
            r_mute_snap <= MUTE;
            r_acc       <= {ACC_W{1'b0}};
            r_ch        <= {CH_W{1'b0}};
            r_state     <= ST_ACCUM;
          end else begin
            r_state     <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          r_acc       <= w_sum;
          r_ch        <= r_ch + CH_W'(1);
          r_in_snap   <= r_in_snap >> IN_WIDTH;
          r_mute_snap <= r_mute_snap >> 1'b1;
          // Result registers load on the last add so OUT_VALID is high during DONE
          if (w_last) begin
            r_state   <= ST_DONE;
            OUT       <= f_sat(w_sum);
            OUT_VALID <= 1'b1;
            CLIPPED   <= f_clip(w_sum);
          end else begin
            r_state   <= ST_ACCUM;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a dropped strobe takes priority over a clear in the same cycle
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_overrun <= 1'b0;
    end else if (IN_STB && BUSY) begin
      r_overrun <= 1'b1;
    end else if (OVERRUN_CLR) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Randomised bench for audio_mixer_seq: two instances (12-bit and 10-bit output) share
// stimulus and are checked every cycle against an arithmetic model of the mixer.
module tb_audio_mixer_seq;

  localparam int NCH = 4;
  localparam int IW  = 10;

  logic                CLK = 1'b0;
  logic                RESET_n = 1'b0;
  logic                IN_STB = 1'b0;
  logic [NCH*IW-1:0]   IN = '0;
  logic [NCH-1:0]      MUTE = '0;
  logic                OVERRUN_CLR = 1'b0;

  logic [11:0] out_w;
  logic        valid_w, clip_w, busy_w, ovr_w;
  logic [9:0]  out_n;
  logic        valid_n, clip_n, busy_n, ovr_n;

  audio_mixer_seq #(.NUM_CH(NCH), .IN_WIDTH(IW), .OUT_WIDTH(12)) dut_w (
    .CLK(CLK), .RESET_n(RESET_n), .IN_STB(IN_STB), .IN(IN), .MUTE(MUTE),
    .OVERRUN_CLR(OVERRUN_CLR), .OUT(out_w), .OUT_VALID(valid_w), .CLIPPED(clip_w),
    .BUSY(busy_w), .OVERRUN(ovr_w));

  audio_mixer_seq #(.NUM_CH(NCH), .IN_WIDTH(IW), .OUT_WIDTH(10)) dut_n (
    .CLK(CLK), .RESET_n(RESET_n), .IN_STB(IN_STB), .IN(IN), .MUTE(MUTE),
    .OVERRUN_CLR(OVERRUN_CLR), .OUT(out_n), .OUT_VALID(valid_n), .CLIPPED(clip_n),
    .BUSY(busy_n), .OVERRUN(ovr_n));

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: accepted jobs with the cycle their result is due
  typedef struct { int due; int sum; } job_t;
  job_t pq[$];
  int   n = 0;
  int   last_acc = -1000;
  logic m_ovr = 1'b0;
  int   m_out12 = 0;
  int   m_out10 = 0;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, n, obs, expv);
    end
  endtask

  function automatic int sat(input int s, input int w);
    int mx;
    int mn;
    mx = (1 <<< (w - 1)) - 1;
    mn = -(1 <<< (w - 1));
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
  endfunction

  function automatic logic model_busy(input int c);
    return (c - last_acc >= 1) && (c - last_acc <= NCH);
  endfunction

  function automatic int rnd_ch();
    case ($urandom_range(0, 3))
      0:       return 511;
      1:       return -512;
      default: return int'($urandom_range(0, 1023)) - 512;
    endcase
  endfunction

  task automatic set_ch(input int a, input int b, input int c, input int d,
                        input logic [NCH-1:0] m);
    int v[NCH];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < NCH; k++) IN[k*IW +: IW] = v[k][IW-1:0];
    MUTE = m;
  endtask

  task automatic check_outputs();
    logic ev;
    int   s;
    logic c12;
    logic c10;
    ev = 1'b0; c12 = 1'b0; c10 = 1'b0;
    if (pq.size() > 0 && pq[0].due == n) begin
      s = pq.pop_front().sum;
      ev = 1'b1;
      m_out12 = sat(s, 12);
      m_out10 = sat(s, 10);
      c12 = (m_out12 != s);
      c10 = (m_out10 != s);
    end
    check_val("valid12", valid_w, ev);
    check_val("valid10", valid_n, ev);
    check_val("out12", $signed(out_w), m_out12);
    check_val("out10", $signed(out_n), m_out10);
    check_val("clip12", clip_w, c12);
    check_val("clip10", clip_n, c10);
    check_val("busy12", busy_w, model_busy(n));
    check_val("busy10", busy_n, model_busy(n));
    check_val("overrun", ovr_w, m_ovr);
    check_val("overrun10", ovr_n, m_ovr);
  endtask

  // One clock: present stb/clr with current IN/MUTE, advance, scramble inputs, check
  task automatic cycle(input logic stb, input logic clr);
    int s;
    IN_STB = stb;
    OVERRUN_CLR = clr;
    if (stb && !model_busy(n)) begin
      s = 0;
      for (int k = 0; k < NCH; k++)
        if (!MUTE[k]) s += int'($signed(IN[k*IW +: IW]));
      pq.push_back('{due: n + NCH + 1, sum: s});
      last_acc = n;
    end
    if (stb && model_busy(n)) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(posedge CLK);
    #1;
    n++;
    IN_STB = 1'b0;
    OVERRUN_CLR = 1'b0;
    IN = {$urandom, $urandom};
    MUTE = NCH'($urandom);
    check_outputs();
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge
  task automatic do_reset();
    RESET_n = 1'b0;
    #2;
    pq.delete();
    last_acc = -1000;
    m_ovr = 1'b0;
    m_out12 = 0;
    m_out10 = 0;
    check_outputs();
    @(posedge CLK);
    #1;
    n++;
    RESET_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    #3;
    do_reset();
    idle(1);

    set_ch(100, -50, 7, 0, 4'b0000);   cycle(1'b1, 1'b0); idle(6);
    set_ch(511, 511, 511, 511, 4'b0000); cycle(1'b1, 1'b0); idle(6);
    set_ch(-512, -512, -512, -512, 4'b0000); cycle(1'b1, 1'b0); idle(6);
    set_ch(-512, -512, -512, -512, 4'b1111); cycle(1'b1, 1'b0); idle(6);

    set_ch(300, 200, -1, 5, 4'b0100);  cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    set_ch(1, 1, 1, 1, 4'b0000);       cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    set_ch(-7, 20, 511, -512, 4'b0000); cycle(1'b1, 1'b0);
    idle(6);

    set_ch(11, 22, 33, 44, 4'b0000);   cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    idle(2);
    do_reset();
    idle(6);
    set_ch(-1, -2, -3, -4, 4'b0001);   cycle(1'b1, 1'b0); idle(6);

    for (int i = 0; i < 600; i++) begin
      set_ch(rnd_ch(), rnd_ch(), rnd_ch(), rnd_ch(),
             ($urandom_range(0, 3) == 0) ? NCH'($urandom) : 4'b0000);
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
